// File: rtl/fifo_nohs_ctrl_if.sv
// Producer and consumer valid/ready bundle for fifo_nohs_ctrl.
// master = producers/consumer side, slave = controller side.
interface fifo_nohs_ctrl_if #(
  parameter int unsigned N_REQ = 2,
  parameter type DATA_T = logic [7:0]
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  DATA_T            req_data [N_REQ];
  logic             cons_valid;
  logic             cons_ready;
  DATA_T            cons_data;

  modport master (
    output req_valid, req_data, cons_ready,
    input  req_ready, cons_valid, cons_data
  );

  modport slave (
    input  req_valid, req_data, cons_ready,
    output req_ready, cons_valid, cons_data
  );
endinterface

// File: rtl/fifo_nohs_ctrl.sv
// Round-robin producer arbiter and occupancy tracker driving a no-handshake FIFO.
// Optional macro FIFO_CTRL_FULL_PASSTHROUGH_EN allows a push into a full FIFO when it pops that cycle.
module fifo_nohs_ctrl #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned DEPTH = 4,
  parameter type DATA_T = logic [7:0],
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  fifo_nohs_ctrl_if.slave  bus,
  output logic             fifo_push_o,
  output logic             fifo_pop_o,
  output logic             fifo_flush_o,
  output DATA_T            fifo_data_o,
  input  DATA_T            fifo_data_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] nxt_ptr;
  logic [N_REQ-1:0] grant;
  logic             gnt_any;
  logic             push_ok;
  int unsigned      scan_c;

  assign count_o      = count_q;
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign fifo_flush_o = flush_i;

  // Handshakes are held off while reset is asserted so nothing is in flight.
  assign bus.cons_valid = rst_n_i && !empty_o && !flush_i;
  assign bus.cons_data  = fifo_data_i;
  assign fifo_pop_o     = bus.cons_valid && bus.cons_ready;

`ifdef FIFO_CTRL_FULL_PASSTHROUGH_EN
  assign push_ok = rst_n_i && (!full_o || fifo_pop_o) && !flush_i;
`else
  assign push_ok = rst_n_i && !full_o && !flush_i;
`endif

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan_c  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_c = 32'(rr_ptr_q) + i;
      if (scan_c >= N_REQ) scan_c = scan_c - N_REQ;
      if (push_ok && !gnt_any && bus.req_valid[PTR_W'(scan_c)]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(scan_c);
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = grant;
  assign fifo_push_o   = gnt_any;
  assign fifo_data_o   = gnt_any ? bus.req_data[gnt_idx] : '0;
  assign nxt_ptr       = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);

  // Occupancy and round-robin pointer; flush empties but keeps fairness state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      if (fifo_push_o && !fifo_pop_o) begin
        count_q <= count_q + CNT_W'(1);
      end else if (fifo_pop_o && !fifo_push_o) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (gnt_any) rr_ptr_q <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_fifo_nohs_ctrl.sv
// Bench for fifo_nohs_ctrl: acts as the external FIFO and checks every cycle against a queue model.
// Build with FIFO_CTRL_FULL_PASSTHROUGH_EN defined to exercise the pass-through variant.
module tb_fifo_nohs_ctrl;
  localparam int N_REQ = 2;
  localparam int DEPTH = 4;
`ifdef FIFO_CTRL_FULL_PASSTHROUGH_EN
  localparam bit PASSTHRU = 1'b1;
`else
  localparam bit PASSTHRU = 1'b0;
`endif

  logic       clk_i;
  logic       rst_n_i;
  logic       flush_i;
  logic       fifo_push_o, fifo_pop_o, fifo_flush_o;
  logic [7:0] fifo_data_o;
  logic [7:0] fifo_data_i;
  logic [2:0] count_o;
  logic       full_o, empty_o;

  fifo_nohs_ctrl_if #(.N_REQ(N_REQ), .DATA_T(logic [7:0])) bus ();

  fifo_nohs_ctrl #(.N_REQ(N_REQ), .DEPTH(DEPTH), .DATA_T(logic [7:0])) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .bus         (bus),
    .fifo_push_o (fifo_push_o),
    .fifo_pop_o  (fifo_pop_o),
    .fifo_flush_o(fifo_flush_o),
    .fifo_data_o (fifo_data_o),
    .fifo_data_i (fifo_data_i),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFO contents as a queue, fairness as "who was granted last".
  logic [7:0] q[$];
  int         last_g = N_REQ - 1;
  bit         armed = 1'b0;
  int         e_g;
  bit         e_cvalid, e_pop, e_push;
  logic [7:0] e_data;

  initial fifo_data_i = 8'h00;

  always @(negedge clk_i) begin
    bit full, ok;
    int idx;
    full     = (q.size() == DEPTH);
    e_cvalid = rst_n_i && (q.size() != 0) && !flush_i;
    e_pop    = e_cvalid && bus.cons_ready;
    ok       = rst_n_i && !flush_i && (!full || (PASSTHRU && e_pop));
    e_g      = -1;
    if (ok) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (last_g + k) % N_REQ;
        if (e_g < 0 && bus.req_valid[idx]) e_g = idx;
      end
    end
    e_push = (e_g >= 0);
    e_data = e_push ? bus.req_data[e_g] : 8'h00;
    if (armed) begin
      cmp("req_ready", int'(bus.req_ready), e_push ? (1 << e_g) : 0);
      cmp("fifo_push", int'(fifo_push_o), int'(e_push));
      cmp("fifo_data", int'(fifo_data_o), int'(e_data));
      cmp("fifo_pop", int'(fifo_pop_o), int'(e_pop));
      cmp("fifo_flush", int'(fifo_flush_o), int'(flush_i));
      cmp("cons_valid", int'(bus.cons_valid), int'(e_cvalid));
      if (e_cvalid) cmp("cons_data", int'(bus.cons_data), int'(q[0]));
      cmp("count", int'(count_o), q.size());
      cmp("full", int'(full_o), int'(full));
      cmp("empty", int'(empty_o), int'(q.size() == 0));
    end
  end

  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      q.delete();
      last_g = N_REQ - 1;
      armed  = 1'b1;
    end else if (flush_i) begin
      q.delete();
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_push) begin
        q.push_back(e_data);
        last_g = e_g;
      end
    end
    fifo_data_i = (q.size() != 0) ? q[0] : 8'h00;
  end

  task automatic cyc(input logic [1:0] v, input logic cr, input logic fl,
                     input logic [7:0] d0, input logic [7:0] d1);
    bus.req_valid   = v;
    bus.cons_ready  = cr;
    flush_i         = fl;
    bus.req_data[0] = d0;
    bus.req_data[1] = d1;
    @(negedge clk_i);
    #1;
  endtask

  task automatic adv;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] drained [4];
    drained[0] = 8'h10; drained[1] = 8'h21; drained[2] = 8'h12; drained[3] = 8'h23;

    // Reset with requests pending.
    rst_n_i = 1'b0;
    cyc(2'b11, 1'b1, 1'b0, 8'h01, 8'h02);
    cmp("rst_ready", int'(bus.req_ready), 0);
    cmp("rst_push", int'(fifo_push_o), 0);
    cmp("rst_cvalid", int'(bus.cons_valid), 0);
    cmp("rst_empty", int'(empty_o), 1);
    adv;
    rst_n_i = 1'b1;
    cyc(2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    cmp("idle_count", int'(count_o), 0);
    cmp("idle_empty", int'(empty_o), 1);

    // Fill with both requesters valid: grants 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      adv;
      cyc(2'b11, 1'b0, 1'b0, 8'(8'h10 + i), 8'(8'h20 + i));
      cmp("fill_grant", int'(bus.req_ready), (i % 2 == 0) ? 1 : 2);
      cmp("fill_count", int'(count_o), i);
    end
    adv;
    cyc(2'b11, 1'b0, 1'b0, 8'h14, 8'h24);
    cmp("full_count", int'(count_o), 4);
    cmp("full_flag", int'(full_o), 1);
    cmp("full_ready", int'(bus.req_ready), 0);

    // Drain in push order.
    for (int i = 0; i < 4; i++) begin
      adv;
      cyc(2'b00, 1'b1, 1'b0, 8'h00, 8'h00);
      cmp("drain_data", int'(bus.cons_data), int'(drained[i]));
      cmp("drain_pop", int'(fifo_pop_o), 1);
      cmp("drain_count", int'(count_o), 4 - i);
    end
    adv;
    cyc(2'b00, 1'b1, 1'b0, 8'h00, 8'h00);
    cmp("drained_cvalid", int'(bus.cons_valid), 0);
    cmp("drained_empty", int'(empty_o), 1);

    // Simultaneous push and pop at count 2.
    adv; cyc(2'b01, 1'b0, 1'b0, 8'h30, 8'h00);
    adv; cyc(2'b01, 1'b0, 1'b0, 8'h31, 8'h00);
    adv; cyc(2'b10, 1'b1, 1'b0, 8'h00, 8'h42);
    cmp("pp_count", int'(count_o), 2);
    cmp("pp_ready", int'(bus.req_ready), 2);
    cmp("pp_pop", int'(fifo_pop_o), 1);
    cmp("pp_head", int'(bus.cons_data), 8'h30);
    adv; cyc(2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    cmp("pp_count_after", int'(count_o), 2);
    cmp("pp_head_after", int'(bus.cons_data), 8'h31);

    // Flush at count 3 with requesters valid.
    adv; cyc(2'b01, 1'b0, 1'b0, 8'h50, 8'h00);
    adv; cyc(2'b11, 1'b0, 1'b1, 8'h55, 8'h56);
    cmp("fl_count", int'(count_o), 3);
    cmp("fl_ready", int'(bus.req_ready), 0);
    cmp("fl_flush", int'(fifo_flush_o), 1);
    cmp("fl_cvalid", int'(bus.cons_valid), 0);
    adv; cyc(2'b11, 1'b0, 1'b0, 8'h60, 8'h61);
    cmp("postfl_count", int'(count_o), 0);
    cmp("postfl_grant", int'(bus.req_ready), 2);
    cmp("postfl_data", int'(fifo_data_o), 8'h61);

    // Full, consumer ready, requester 0 valid.
    adv; cyc(2'b01, 1'b0, 1'b0, 8'h70, 8'h00);
    adv; cyc(2'b10, 1'b0, 1'b0, 8'h00, 8'h71);
    adv; cyc(2'b01, 1'b0, 1'b0, 8'h72, 8'h00);
    adv; cyc(2'b01, 1'b1, 1'b0, 8'h73, 8'h00);
    cmp("fp_full", int'(full_o), 1);
    cmp("fp_pop", int'(fifo_pop_o), 1);
    cmp("fp_head", int'(bus.cons_data), 8'h61);
    cmp("fp_grant", int'(bus.req_ready), PASSTHRU ? 1 : 0);
    adv; cyc(2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    cmp("fp_count", int'(count_o), PASSTHRU ? 4 : 3);

    // Reset in the middle of traffic.
    adv;
    rst_n_i = 1'b0;
    cyc(2'b11, 1'b1, 1'b0, 8'h80, 8'h81);
    cmp("mrst_ready", int'(bus.req_ready), 0);
    cmp("mrst_pop", int'(fifo_pop_o), 0);
    adv;
    rst_n_i = 1'b1;
    cyc(2'b11, 1'b0, 1'b0, 8'h90, 8'h91);
    cmp("mrst_count", int'(count_o), 0);
    cmp("mrst_grant", int'(bus.req_ready), 1);

    // Mixed traffic, checked by the per-cycle model.
    for (int k = 0; k < 80; k++) begin
      adv;
      cyc(2'((k * 5 + k / 3) & 3), (k % 3) != 0, (k % 17) == 16,
          8'(k), 8'(8'h80 + k));
    end
    adv;
    cyc(2'b00, 1'b0, 1'b0, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
